// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bundle: program-counter hooks, instruction-memory read port, decode handoff and error flag.
// The master modport is the fetch unit's view; slave is the surrounding pipeline and memory.
interface instr_fetch_unit_if #(
    parameter int AW = 8,
    parameter int IW = 16
);
    logic [AW-1:0] pc;
    logic          pc_adv;
    logic          flush;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [IW-1:0] mem_rdata;
    logic          if_valid;
    logic          if_ready;
    logic [IW-1:0] if_instr;
    logic [AW-1:0] if_pc;
    logic          fetch_err;

    modport master (
        input  pc, flush, mem_ack, mem_rdata, if_ready,
        output pc_adv, mem_req, mem_addr, if_valid, if_instr, if_pc, fetch_err
    );

    modport slave (
        output pc, flush, mem_ack, mem_rdata, if_ready,
        input  pc_adv, mem_req, mem_addr, if_valid, if_instr, if_pc, fetch_err
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: one outstanding memory read at a time feeding a 2-entry {pc, instr} FIFO.
// Define IFU_TIMEOUT_EN to abandon reads unanswered for 16 cycles and raise a sticky fetch_err.
module instr_fetch_unit #(
    parameter int AW = 8,
    parameter int IW = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instr_fetch_unit_if.master    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic          pc_adv_q, pc_adv_d;

    logic [AW-1:0] fifo_pc_q    [2];
    logic [IW-1:0] fifo_instr_q [2];
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic [1:0]    count_q, count_d;

    logic          push;
    logic          pop;
    logic          timeout;

    assign push = (state_q == ST_WAIT) && bus.mem_ack && !bus.flush;
    assign pop  = (count_q != 2'd0) && bus.if_ready;

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        pc_adv_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!bus.flush && (count_q < 2'd2)) begin
                    state_d    = ST_WAIT;
                    mem_req_d  = 1'b1;
                    mem_addr_d = bus.pc;
                    pc_adv_d   = 1'b1;
                end
            end
            ST_WAIT: begin
                if (bus.mem_ack || timeout) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                end else if (bus.flush) begin
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (bus.mem_ack || timeout) begin
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            pc_adv_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            pc_adv_q   <= pc_adv_d;
        end
    end

    // Flush clears the FIFO outright, overriding any push or pop in the same cycle.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.flush) begin
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
            count_d  = 2'd0;
        end else begin
            if (push) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            count_q         <= 2'd0;
            fifo_pc_q[0]    <= '0;
            fifo_pc_q[1]    <= '0;
            fifo_instr_q[0] <= '0;
            fifo_instr_q[1] <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (push) begin
                fifo_pc_q[wr_ptr_q]    <= mem_addr_q;
                fifo_instr_q[wr_ptr_q] <= bus.mem_rdata;
            end
        end
    end

`ifdef IFU_TIMEOUT_EN
    logic [3:0] tmo_cnt_q, tmo_cnt_d;
    logic       fetch_err_q, fetch_err_d;

    assign timeout = (tmo_cnt_q == 4'd15);

    // Held at zero while idle so every new request starts a fresh count; 15+1 wraps back to zero.
    always_comb begin
        tmo_cnt_d   = tmo_cnt_q;
        fetch_err_d = fetch_err_q;
        if (state_q == ST_IDLE) begin
            tmo_cnt_d = 4'd0;
        end else if (!bus.mem_ack) begin
            tmo_cnt_d = tmo_cnt_q + 4'd1;
            if (timeout) begin
                fetch_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q   <= 4'd0;
            fetch_err_q <= 1'b0;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign bus.fetch_err = fetch_err_q;
`else
    assign timeout       = 1'b0;
    assign bus.fetch_err = 1'b0;
`endif

    assign bus.mem_req  = mem_req_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.pc_adv   = pc_adv_q;
    assign bus.if_valid = (count_q != 2'd0);
    assign bus.if_instr = (count_q != 2'd0) ? fifo_instr_q[rd_ptr_q] : '0;
    assign bus.if_pc    = (count_q != 2'd0) ? fifo_pc_q[rd_ptr_q]    : '0;

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter AW, default 8: instruction address width; matches the program counter width.
REQ-002 Parameter IW, default 16: instruction word width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 pc  input  AW  current fetch address from the program counter.
REQ-006 pc_adv  output  1  one-cycle pulse per issued fetch; drives the program counter's nia.
REQ-007 flush  input  1  branch/redirect; discards buffered and in-flight fetches.
REQ-008 mem_req  output  1  instruction memory read request.
REQ-009 mem_addr  output  AW  registered read address.
REQ-010 mem_ack  input  1  memory read complete; mem_rdata valid in the same cycle.
REQ-011 mem_rdata  input  IW  instruction read data.
REQ-012 if_valid  output  1  if_instr/if_pc hold a valid entry for decode.
REQ-013 if_ready  input  1  decode accepts the entry.
REQ-014 if_instr  output  IW  head instruction.
REQ-015 if_pc  output  AW  address of the head instruction.
REQ-016 fetch_err  output  1  sticky memory timeout flag.

Function
REQ-017 FSM states: IDLE, WAIT (request outstanding), DROP (request outstanding, result to be discarded).
REQ-018 Buffering: 2-entry FIFO of {pc, instr}; if_valid = FIFO not empty; if_instr/if_pc = head entry.
REQ-019 Issue: in IDLE with flush=0 and FIFO count < 2, the block sets mem_req=1, registers mem_addr=pc, pulses pc_adv for exactly one cycle, and enters WAIT.
REQ-020 Handshake: mem_req and mem_addr stay stable from issue until the cycle mem_ack=1; mem_req drops the following cycle.
REQ-021 WAIT with mem_ack=1 and flush=0: push {mem_addr, mem_rdata}, go to IDLE.
REQ-022 Only one request is outstanding at a time; at most one fetch is issued per IDLE visit, so the FIFO cannot overflow.
REQ-023 Pop: if_valid and if_ready in the same cycle removes the head; push and pop in the same cycle leave the count unchanged.
REQ-024 Latency: mem_ack in cycle M makes the entry visible (if_valid=1 when the FIFO was empty) in cycle M+1; minimum issue-to-if_valid latency is 2 cycles.
REQ-025 flush empties the FIFO at the clock edge (if_valid=0 next cycle), so a same-cycle push or pop has no effect.
REQ-026 flush in WAIT without mem_ack: go to DROP, with mem_req held; DROP with mem_ack: discard data, go to IDLE.
REQ-027 flush in WAIT with mem_ack: discard data, go to IDLE.
REQ-028 flush in IDLE: no issue that cycle.
REQ-029 Address arithmetic is AW bits wide and wraps modulo 2^AW; the block never computes addresses itself and always uses pc.

Reset
REQ-030 rst_n low asynchronously forces state IDLE, FIFO empty, mem_req=0, mem_addr=0, pc_adv=0, if_valid=0, if_instr=0, if_pc=0, fetch_err=0, timeout counter=0.
REQ-031 Reset asserted mid-request abandons the request; any mem_ack after reset release while in IDLE is ignored.

Configuration
REQ-032 Macro IFU_TIMEOUT_EN defined: a 4-bit counter increments each cycle in WAIT or DROP without mem_ack and clears on entry to WAIT.
REQ-033 On reaching 15, the block drops mem_req, sets fetch_err=1 (sticky until reset), pushes nothing and returns to IDLE.
REQ-034 IFU_TIMEOUT_EN undefined: no counter, fetch_err is tied to 0, and the block waits for mem_ack indefinitely.

Verification
REQ-035 pc=0x10, if_ready=1, mem_ack 1 cycle after req, rdata=0xA5C3 -> one pc_adv pulse, mem_addr=0x10, if_valid for one cycle with if_instr=0xA5C3, if_pc=0x10.
REQ-036 if_ready=0, pc steps 0x20,0x21,0x22 with immediate acks -> exactly 2 fetches (0x20,0x21), no third mem_req until a pop, entries pop in order.
REQ-037 flush asserted 1 cycle after issue at pc=0x30, ack 3 cycles later -> mem_req held until ack, data discarded, if_valid stays 0, next fetch uses new pc.
REQ-038 FIFO full, flush and pop in the same cycle -> if_valid=0 next cycle, count 0.
REQ-039 IFU_TIMEOUT_EN defined, mem_ack never asserted -> mem_req falls 16 cycles after issue, fetch_err=1 until rst_n low; undefined -> mem_req stays high and fetch_err=0.
REQ-040 rst_n low during WAIT -> all outputs return to reset values immediately, without waiting for clk.
